// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU subsystem: serializer state encoding and byte width.
package alu_sys_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      GAP  = 2'b10
   } ser_state_e;

endpackage

// File: rtl/alu_result_serializer.sv
// Streams each ALU result to the UART transmitter one byte at a time, LSB first.
// One result is held in the shift register and a second can wait in the pending
// buffer; a result arriving with both occupied is dropped and flagged in overflow.
//
// state | meaning
// IDLE  | shift register empty, waiting for a result
// SEND  | tx_valid high, presenting the current byte until tx_busy is low
// GAP   | one idle cycle after each transfer so the UART can raise tx_busy
module alu_result_serializer
   import alu_sys_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             out_valid,
   input  logic             tx_busy,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   output logic             ser_busy,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int BYTES = WIDTH / BYTE_W;
   localparam int IDX_W = $clog2(BYTES + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES);

   ser_state_e         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [WIDTH-1:0]   pend_q, pend_d;
   logic               pend_full_q, pend_full_d;
   logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
   logic               ovf_q, ovf_d;
   logic               ser_busy_q, ser_busy_d;
   logic               pend_move;
   logic               ovf_set;

   // Next-state, datapath and pending-buffer decisions.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shreg_d     = shreg_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      tx_data_d   = tx_data_q;
      ovf_d       = ovf_q;
      pend_move   = 1'b0;
      ovf_set     = 1'b0;

      case (state_q)
         IDLE: begin
            if (out_valid) begin
               shreg_d   = alu_out;
               idx_d     = '0;
               tx_data_d = alu_out[BYTE_W-1:0];
               state_d   = SEND;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               shreg_d = shreg_q >> BYTE_W;
               idx_d   = idx_q + IDX_W'(1);
               state_d = GAP;
            end
         end
         GAP: begin
            if (idx_q != IDX_LAST) begin
               tx_data_d = shreg_q[BYTE_W-1:0];
               state_d   = SEND;
            end else if (pend_full_q) begin
               shreg_d     = pend_q;
               pend_full_d = 1'b0;
               idx_d       = '0;
               tx_data_d   = pend_q[BYTE_W-1:0];
               pend_move   = 1'b1;
               state_d     = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A slot freed by the pending-to-shift move can be refilled in the same cycle.
      if (out_valid && (state_q != IDLE)) begin
         if (!pend_full_q || pend_move) begin
            pend_d      = alu_out;
            pend_full_d = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end

      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end

      ser_busy_d = (state_d != IDLE) | pend_full_d;
   end

   // State and data registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         shreg_q     <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         tx_data_q   <= '0;
         ovf_q       <= 1'b0;
         ser_busy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         tx_data_q   <= tx_data_d;
         ovf_q       <= ovf_d;
         ser_busy_q  <= ser_busy_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = (state_q == SEND);
   assign ser_busy = ser_busy_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer (WIDTH=16).
module tb_alu_result_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] alu_out;
   logic        out_valid;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        ser_busy;
   logic        overflow;
   logic        ovf_clr;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  rx_q[$];
   int          rx_cyc[$];
   int          n0;

   alu_result_serializer #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_out   (alu_out),
      .out_valid (out_valid),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .ser_busy  (ser_busy),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   // Cycle counter: value seen after a rising edge is the index of the cycle that edge began.
   always @(posedge clk) cyc <= cyc + 1;

   // Record every byte the UART accepts, with the cycle it was accepted in.
   always @(negedge clk) begin
      if (!rst && tx_valid && !tx_busy) begin
         rx_q.push_back(tx_data);
         rx_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [15:0] v);
      alu_out   = v;
      out_valid = 1'b1;
      tick();
      out_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && ser_busy; i++) tick();
      check_eq("idle_timeout", {31'd0, ser_busy}, 32'd0);
   endtask

   task automatic rx_clear();
      rx_q.delete();
      rx_cyc.delete();
   endtask

   function automatic logic [31:0] rx_at(input int i);
      if (i < rx_q.size()) return {24'd0, rx_q[i]};
      return 32'hDEAD;
   endfunction

   function automatic int rx_cyc_at(input int i);
      if (i < rx_cyc.size()) return rx_cyc[i];
      return -1;
   endfunction

   initial begin
      rst       = 1'b1;
      out_valid = 1'b1;
      alu_out   = 16'hFFFF;
      tx_busy   = 1'b0;
      ovf_clr   = 1'b0;

      // Reset dominates a pending out_valid.
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
         check_eq("rst_tx_data",  {24'd0, tx_data},  32'd0);
         check_eq("rst_ser_busy", {31'd0, ser_busy}, 32'd0);
         check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
      end
      rst       = 1'b0;
      out_valid = 1'b0;
      tick();

      // Single result, exact cycle timing.
      rx_clear();
      n0 = cyc;
      pulse(16'hA55A);
      check_eq("s_n1_valid", {31'd0, tx_valid}, 32'd1);
      check_eq("s_n1_data",  {24'd0, tx_data},  32'h5A);
      tick();
      check_eq("s_n2_valid", {31'd0, tx_valid}, 32'd0);
      check_eq("s_n2_hold",  {24'd0, tx_data},  32'h5A);
      tick();
      check_eq("s_n3_valid", {31'd0, tx_valid}, 32'd1);
      check_eq("s_n3_data",  {24'd0, tx_data},  32'hA5);
      tick();
      check_eq("s_n4_valid", {31'd0, tx_valid}, 32'd0);
      check_eq("s_n4_busy",  {31'd0, ser_busy}, 32'd1);
      tick();
      check_eq("s_n5_busy",  {31'd0, ser_busy}, 32'd0);
      check_eq("s_n5_valid", {31'd0, tx_valid}, 32'd0);
      check_eq("s_cnt",   rx_q.size(), 32'd2);
      check_eq("s_b0",    rx_at(0), 32'h5A);
      check_eq("s_b1",    rx_at(1), 32'hA5);
      check_eq("s_t0",    rx_cyc_at(0) - n0, 32'd1);
      check_eq("s_t1",    rx_cyc_at(1) - n0, 32'd3);

      // Busy stall on byte1.
      rx_clear();
      pulse(16'h1234);
      tick();
      tx_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("st_valid", {31'd0, tx_valid}, 32'd1);
         check_eq("st_data",  {24'd0, tx_data},  32'h12);
      end
      tick();
      tx_busy = 1'b0;
      check_eq("st_rel_valid", {31'd0, tx_valid}, 32'd1);
      check_eq("st_rel_data",  {24'd0, tx_data},  32'h12);
      tick();
      check_eq("st_after_valid", {31'd0, tx_valid}, 32'd0);
      wait_idle();
      check_eq("st_cnt", rx_q.size(), 32'd2);
      check_eq("st_b0",  rx_at(0), 32'h34);
      check_eq("st_b1",  rx_at(1), 32'h12);

      // Back-to-back results through the pending buffer.
      rx_clear();
      n0 = cyc;
      pulse(16'h0102);
      pulse(16'h0304);
      wait_idle();
      check_eq("bb_cnt", rx_q.size(), 32'd4);
      check_eq("bb_b0",  rx_at(0), 32'h02);
      check_eq("bb_b1",  rx_at(1), 32'h01);
      check_eq("bb_b2",  rx_at(2), 32'h04);
      check_eq("bb_b3",  rx_at(3), 32'h03);
      check_eq("bb_t2",  rx_cyc_at(2) - n0, 32'd5);
      check_eq("bb_t3",  rx_cyc_at(3) - n0, 32'd7);
      check_eq("bb_ovf", {31'd0, overflow}, 32'd0);

      // Overflow: third result dropped while UART is busy.
      rx_clear();
      tx_busy = 1'b1;
      pulse(16'h1111);
      pulse(16'h2222);
      pulse(16'h3333);
      check_eq("ov_set",  {31'd0, overflow}, 32'd1);
      check_eq("ov_busy", {31'd0, ser_busy}, 32'd1);
      tx_busy = 1'b0;
      wait_idle();
      check_eq("ov_cnt", rx_q.size(), 32'd4);
      check_eq("ov_b0",  rx_at(0), 32'h11);
      check_eq("ov_b1",  rx_at(1), 32'h11);
      check_eq("ov_b2",  rx_at(2), 32'h22);
      check_eq("ov_b3",  rx_at(3), 32'h22);
      check_eq("ov_sticky", {31'd0, overflow}, 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_eq("ov_clr", {31'd0, overflow}, 32'd0);

      // Drop and clear in the same cycle: set wins.
      tx_busy = 1'b1;
      pulse(16'h4444);
      pulse(16'h5555);
      ovf_clr = 1'b1;
      pulse(16'h6666);
      ovf_clr = 1'b0;
      check_eq("ov_set_wins", {31'd0, overflow}, 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_eq("ov_clr2", {31'd0, overflow}, 32'd0);
      tx_busy = 1'b0;
      wait_idle();

      // Reset mid-transfer discards the shift register and the pending buffer.
      pulse(16'hBEEF);
      pulse(16'h5555);
      rst = 1'b1;
      tick();
      check_eq("mr_valid",   {31'd0, tx_valid}, 32'd0);
      check_eq("mr_busy",    {31'd0, ser_busy}, 32'd0);
      check_eq("mr_data",    {24'd0, tx_data},  32'd0);
      rst = 1'b0;
      tick();
      rx_clear();
      tick();
      check_eq("mr_quiet", rx_q.size(), 32'd0);
      pulse(16'h0A0B);
      wait_idle();
      tick();
      tick();
      check_eq("mr_cnt", rx_q.size(), 32'd2);
      check_eq("mr_b0",  rx_at(0), 32'h0B);
      check_eq("mr_b1",  rx_at(1), 32'h0A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
